// File: rtl/instr_pkg.sv
// Shared definitions for the instruction issue block.
// Holds the instruction width, the halt sentinel, the default reset PC and
// the ROM image as a lookup function (words past the program read HALT_WORD).
package instr_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] HALT_WORD        = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // ROM image indexed by word number.
    function automatic logic [INSTR_W-1:0] rom_word(input int unsigned idx);
        case (idx)
            0:       return 32'h0002_3820;
            1:       return 32'h00E2_F822;
            2:       return 32'h0022_F82A;
            3:       return 32'hAC22_0000;
            4:       return 32'h8C3F_0000;
            default: return HALT_WORD;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO between fetch and the execute stage.
// Ports:
//   clk          clock
//   flush_i      synchronous flush, empties the buffer (wins over push/pop)
//   push_i       write push_data_i (taken when not full, or full with a pop)
//   push_data_i  payload {pc, instr}
//   pop_i        remove the head (ignored when empty)
//   pop_data_o   head payload, undefined when empty
//   full_o       two entries held
//   empty_o      no entries held
module instr_fifo2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o     = (cnt_q == 2'd2);
    assign empty_o    = (cnt_q == 2'd0);
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok  = pop_i && !empty_o;
        // A full buffer still accepts a push when the head leaves on the same edge.
        push_ok = push_i && (!full_o || pop_ok);
        cnt_d   = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction fetch/issue front end: a PC walks a small ROM and pushes
// {pc, instr} into a 2-entry buffer drained by the execute stage with a
// valid/ready handshake. Fetching the halt sentinel stops fetch; a redirect
// flushes the buffer and restarts fetch at a new address.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   instr        instruction at the buffer head (0 when not valid)
//   pc_out       byte address of instr (0 when not valid)
//   instr_valid  instr/pc_out hold a valid instruction
//   instr_ready  execute stage accepts instr this cycle
//   redirect     taken branch/jump, refetch from redirect_pc
//   redirect_pc  new fetch byte address, bits [1:0] ignored
//   halt         sentinel fetched, fetch stopped
module instr_issue
    import instr_pkg::*;
#(
    parameter int          ROM_DEPTH = 16,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               halt
);

    localparam int IDX_W = $clog2(ROM_DEPTH);

    logic [31:0]        pc_q, pc_d;
    logic               halt_q, halt_d;
    logic [IDX_W-1:0]   rom_idx;
    logic [INSTR_W-1:0] fetch_word;
    logic               fetch_en;
    logic               fetch_is_halt;
    logic               fifo_push, fifo_pop, fifo_flush;
    logic               fifo_full, fifo_empty;
    logic [63:0]        fifo_head;
    logic               unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^redirect_pc[1:0];

    // Upper PC bits are dropped here, so out-of-range addresses wrap.
    assign rom_idx    = pc_q[IDX_W+1:2];
    assign fetch_word = rom_word(32'(rom_idx));

    always_comb begin
        fetch_en      = !halt_q && !redirect && (!fifo_full || fifo_pop);
        fetch_is_halt = (fetch_word == HALT_WORD);
        fifo_push     = fetch_en && !fetch_is_halt && !rst;
        pc_d          = pc_q;
        halt_d        = halt_q;
        if (redirect) begin
            pc_d   = {redirect_pc[31:2], 2'b00};
            halt_d = 1'b0;
        end else if (fetch_en) begin
            // The sentinel is never issued; pc stays parked on it.
            if (fetch_is_halt) halt_d = 1'b1;
            else               pc_d   = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            halt_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            halt_q <= halt_d;
        end
    end

    // A pop coincident with redirect is still a completed transfer; the
    // flush then discards whatever remains.
    assign fifo_pop   = instr_valid && instr_ready;
    assign fifo_flush = rst || redirect;

    instr_fifo2 #(
        .DATA_W (64)
    ) u_fifo (
        .clk         (clk),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i ({pc_q, fetch_word}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Outputs are forced to zero whenever nothing valid is presented,
    // including the whole time rst is asserted.
    assign instr_valid = !fifo_empty && !rst;
    assign instr       = instr_valid ? fifo_head[31:0]  : '0;
    assign pc_out      = instr_valid ? fifo_head[63:32] : '0;
    assign halt        = halt_q && !rst;

endmodule

// File: tb/tb_instr_issue.sv
module tb_instr_issue;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    logic [63:0] exp_q[$];
    logic        hold_vld = 1'b0;
    logic [63:0] hold_val = '0;

    localparam logic [63:0] NO_EXPECT = 64'hFFFF_FFFF_FFFF_FFFF;

    instr_issue #(
        .ROM_DEPTH (16),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // Reference program for a 16-word ROM.
    function automatic logic [31:0] m_rom(input logic [31:0] byte_addr);
        logic [3:0] idx;
        idx = byte_addr[5:2];
        case (idx)
            4'd0:    return 32'h0002_3820;
            4'd1:    return 32'h00E2_F822;
            4'd2:    return 32'h0022_F82A;
            4'd3:    return 32'hAC22_0000;
            4'd4:    return 32'h8C3F_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h, required %h", tag, obs, exp_v);
        end
    endtask

    // Program-order stream expected from a fetch starting at target.
    task automatic push_seq(input logic [31:0] target);
        logic [31:0] a;
        logic [31:0] w;
        a = {target[31:2], 2'b00};
        for (int k = 0; k < 16; k++) begin
            w = m_rom(a);
            if (w == 32'hFFFF_FFFF) break;
            exp_q.push_back({a, w});
            a = a + 32'd4;
        end
    endtask

    // One clock: drive at negedge, score the transfer the coming edge will
    // perform, then advance to the next negedge.
    task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic [63:0] e;
        rst         = r;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        if (hold_vld && !r) begin
            check("stall_valid", 64'(instr_valid), 64'd1);
            check("stall_data", {pc_out, instr}, hold_val);
        end
        if (!r && instr_valid && rdy) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = NO_EXPECT;
            check("xfer", {pc_out, instr}, e);
            n_xfer++;
        end
        hold_vld = !r && !rd && instr_valid && !rdy;
        hold_val = {pc_out, instr};
        if (r) begin
            exp_q.delete();
            push_seq(32'h0000_0000);
        end else if (rd) begin
            exp_q.delete();
            push_seq(rpc);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int base;
        logic rnd_rdy;
        logic rnd_rd;
        logic [31:0] rnd_pc;

        rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        @(negedge clk);

        // Reset state, then straight-line run to the sentinel with ready high.
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        base = n_xfer;
        drive(0, 1, 0, 0);
        check("lat1_head", {31'd0, instr_valid, pc_out, instr}, {31'd0, 1'b1, 32'h0, 32'h0002_3820});
        for (int k = 0; k < 4; k++) drive(0, 1, 0, 0);
        check("pre_halt", {62'd0, halt, instr_valid}, {62'd0, 1'b0, 1'b1});
        drive(0, 1, 0, 0);
        check("halt_set", {62'd0, halt, instr_valid}, {62'd0, 1'b1, 1'b0});
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        check("run_xfers", 64'(n_xfer - base), 64'd5);
        check("halt_hold", 64'(halt), 64'd1);

        // Consumer stalled: buffer fills, pc parks at 8, then drains without a bubble.
        drive(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 0);
            check("stall_head", {31'd0, instr_valid, pc_out}, {31'd0, 1'b1, 32'h0});
        end
        check("stall_pc", 64'(dut.pc_q), 64'h8);
        base = n_xfer;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            check("b2b_valid", 64'(instr_valid), 64'd1);
        end
        check("b2b_xfers", 64'(n_xfer - base), 64'd3);

        // Redirect with two entries buffered; low address bits ignored.
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_000B);
        check("redir_flush", 64'(instr_valid), 64'd0);
        drive(0, 0, 0, 0);
        check("redir_head", {31'd0, instr_valid, pc_out, instr}, {31'd0, 1'b1, 32'h8, 32'h0022_F82A});
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 0);
        check("redir_halt", 64'(halt), 64'd1);

        // Last ROM word is the sentinel; 0x40 wraps to word 0.
        drive(0, 1, 1, 32'h0000_003C);
        check("last_clr", {62'd0, halt, instr_valid}, {62'd0, 1'b0, 1'b0});
        drive(0, 1, 0, 0);
        check("last_halt", {62'd0, halt, instr_valid}, {62'd0, 1'b1, 1'b0});
        drive(0, 1, 1, 32'h0000_0040);
        check("wrap_clr", {62'd0, halt, instr_valid}, {62'd0, 1'b0, 1'b0});
        drive(0, 0, 0, 0);
        check("wrap_head", {31'd0, instr_valid, pc_out, instr}, {31'd0, 1'b1, 32'h40, 32'h0002_3820});
        for (int k = 0; k < 7; k++) drive(0, 1, 0, 0);
        check("wrap_halt", 64'(halt), 64'd1);

        // Reset out of halt, then reset with a full buffer.
        drive(1, 0, 0, 0);
        check("rst2_halt", {62'd0, halt, instr_valid}, {62'd0, 1'b0, 1'b0});
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 1, 32'h0000_0010);
        check("mid_rst", {instr_valid, halt, pc_out, instr}, {1'b0, 1'b0, 32'h0, 32'h0});
        drive(0, 0, 0, 0);
        check("post_rst", {31'd0, instr_valid, pc_out, instr}, {31'd0, 1'b1, 32'h0, 32'h0002_3820});
        for (int k = 0; k < 7; k++) drive(0, 1, 0, 0);
        check("post_rst_q", 64'(exp_q.size()), 64'd0);

        // Random ready with periodic redirects.
        for (int i = 0; i < 200; i++) begin
            rnd_rdy = ($urandom_range(0, 3) != 0);
            rnd_rd  = ((i % 17) == 16);
            rnd_pc  = 32'($urandom_range(0, 255));
            drive(0, rnd_rdy, rnd_rd, rnd_pc);
        end
        for (int k = 0; k < 20; k++) drive(0, 1, 0, 0);
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_halt", 64'(halt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 The parameter ROM_DEPTH SHALL default to 16 and set the number of 32-bit words in the instruction ROM; it is a power of two.
REQ-002 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the byte address fetched first after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr  output  32  instruction word presented to the execute stage.
REQ-006 pc_out  output  32  byte address of the word on instr.
REQ-007 instr_valid  output  1  instr and pc_out hold a valid instruction.
REQ-008 instr_ready  input  1  execute stage accepts instr this cycle.
REQ-009 redirect  input  1  branch/jump taken; refetch from redirect_pc.
REQ-010 redirect_pc  input  32  new fetch byte address; bits [1:0] are ignored.
REQ-011 halt  output  1  the halt sentinel has been fetched and fetch has stopped.

Function
REQ-012 The ROM SHALL be read combinationally at index pc[log2(ROM_DEPTH)+1:2], so addresses beyond the ROM wrap modulo ROM_DEPTH words.
REQ-013 ROM contents SHALL be, from word 0: 0x00023820, 0x00E2F822, 0x0022F82A, 0xAC220000, 0x8C3F0000, HALT_WORD; every remaining word is HALT_WORD.
REQ-014 HALT_WORD SHALL be 32'hFFFF_FFFF.
REQ-015 Each cycle with the buffer not full, halt low and redirect low, the block SHALL push {pc, ROM[pc]} into a 2-entry FIFO and advance pc by 4.
REQ-016 A fetched HALT_WORD SHALL NOT be pushed; it sets halt on the next edge and freezes pc at the sentinel address.
REQ-017 instr, pc_out and instr_valid SHALL come from the FIFO head; instr_valid = FIFO not empty.
REQ-018 A transfer SHALL occur when instr_valid and instr_ready are both high; the head pops on that edge.
REQ-019 While instr_valid is high and no transfer occurs, instr and pc_out SHALL remain stable.
REQ-020 Push and pop in the same cycle SHALL both take effect, so occupancy is unchanged.
REQ-021 When the FIFO is full (2 entries) and no pop occurs, fetch SHALL stall and pc SHALL hold.
REQ-022 When the FIFO is full and a pop occurs in the same cycle, fetch SHALL proceed and push into the freed entry.
REQ-023 redirect SHALL take priority over push, pop and halt: on that edge the FIFO empties, halt clears, and pc <= {redirect_pc[31:2], 2'b00}.
REQ-024 A transfer coincident with redirect SHALL still count as accepted by the consumer; the instruction is not re-presented.
REQ-025 Latency SHALL be one cycle: a word fetched at edge N is visible on instr with instr_valid high after edge N.
REQ-026 A fetch-to-issue throughput of one instruction per cycle SHALL be sustained while instr_ready stays high.

Reset
REQ-027 While rst is high, the block SHALL drive instr_valid=0, halt=0, instr=0 and pc_out=0, empty the FIFO and set pc=RESET_PC.
REQ-028 rst SHALL override redirect and all in-flight entries; the first fetch occurs on the first edge with rst low.
REQ-029 Reset asserted mid-stream SHALL discard buffered instructions with no partial output.

Structure
REQ-030 HALT_WORD, the ROM init words, instruction width (32) and the default RESET_PC SHALL live in the shared package instr_pkg.
REQ-031 The 2-entry buffer SHALL be a sub-module instr_fifo2 (64-bit payload {pc,instr}, push/pop/full/empty, synchronous flush), instantiated once.
REQ-032 The PC register, ROM, halt flag and redirect logic SHALL reside in instr_issue.

Verification
REQ-033 Reset release with instr_ready=1 -> after 5 transfers the bench sees (pc,instr) = (0,0x00023820), (4,0x00E2F822), (8,0x0022F82A), (C,0xAC220000), (10,0x8C3F0000); halt=1 one cycle after the fetch of 0x14; instr_valid=0 after 0x10 is drained.
REQ-034 instr_ready=0 for 6 cycles after reset -> instr_valid=1 with pc_out=0 held stable, 2 entries buffered, pc stalled at 8; ready=1 -> pc 0,4,8 delivered back-to-back with no bubble.
REQ-035 redirect=1 with redirect_pc=0x0000000B while 2 entries are buffered -> next edge instr_valid=0; following edge pc_out=0x8, instr=0x0022F82A.
REQ-036 redirect_pc=0x3C (last word) with ROM_DEPTH=16 -> HALT_WORD fetched at 0x3C, halt=1; redirect to 0x40 -> wraps to word 0, instr=0x00023820, pc_out=0x40.
REQ-037 rst asserted for 1 cycle mid-stream (FIFO full) -> instr_valid=0 and halt=0 during reset; first post-reset transfer is pc=0, instr=0x00023820.
REQ-038 Random instr_ready toggling over 200 cycles with periodic redirects -> scoreboard confirms no instruction is dropped, duplicated or reordered, and values are stable while stalled.
